// File: rtl/ct_lsu_dcache_pkg.sv
// Shared types and helpers for the load-side dcache tag array.
// Optional DCACHE_TAG_PARITY_EN adds one even-parity bit per stored way.
package ct_lsu_dcache_pkg;

  typedef enum logic {IDLE = 1'b0, INIT = 1'b1} tag_fsm_e;

  localparam int PAR_MAX_W = 64;

  function automatic int way_w(input int tag_w);
`ifdef DCACHE_TAG_PARITY_EN
    return tag_w + 1;
`else
    return tag_w;
`endif
  endfunction

  // Callers zero-extend the way data into the fixed-width argument.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ct_lsu_spsram_bwen.sv
// Behavioural single-port SRAM, active-low CEN/GWEN/per-bit WEN, registered Q.
module ct_lsu_spsram_bwen #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 54,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             CEN_b,
  input  logic             GWEN_b,
  input  logic [WIDTH-1:0] WEN_b,
  input  logic [AW-1:0]    A,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Q only moves on reads, so it holds the last read word across writes.
  always_ff @(posedge CLK)
    if (!CEN_b) begin
      if (!GWEN_b) mem[A] <= (mem[A] & WEN_b) | (D & ~WEN_b);
      else         Q      <= mem[A];
    end
endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based clock gate: enable is sampled while clk_in is low.
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);
  logic en_bf, en_lat;

  assign en_bf = (global_en & (module_en | local_en)) | external_en;

  always_latch
    if (!clk_in) en_lat <= en_bf | pad_yy_icg_scan_en;

  assign clk_out = clk_in & en_lat;
endmodule

// File: rtl/ct_lsu_dcache_tag_array_ctrl.sv
// Dcache tag array controller: valid/ready access port, one-cycle read, invalidate-all walker.
// Define DCACHE_TAG_PARITY_EN to store and check a parity bit per way.
module ct_lsu_dcache_tag_array_ctrl
  import ct_lsu_dcache_pkg::*;
#(
  parameter int NUM_WAY = 2,
  parameter int NUM_SET = 512,
  parameter int TAG_W   = 27,
  parameter int IDX_W   = $clog2(NUM_SET)
) (
  input  logic                     forever_cpuclk,
  input  logic                     cpurst,
  input  logic                     pad_yy_icg_scan_en,
  input  logic                     cp0_lsu_icg_en,
  input  logic                     req_vld,
  output logic                     req_rdy,
  input  logic                     req_wr,
  input  logic [IDX_W-1:0]         req_idx,
  input  logic [NUM_WAY-1:0]       req_way_wen,
  input  logic [NUM_WAY*TAG_W-1:0] req_din,
  input  logic                     inv_all_req,
  output logic                     init_busy,
  output logic                     rd_vld,
  output logic [NUM_WAY*TAG_W-1:0] rd_dout,
  output logic [NUM_WAY-1:0]       par_err
);
  localparam int SW = way_w(TAG_W);
  localparam int MW = NUM_WAY * SW;

  tag_fsm_e         state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             rd_vld_q, rd_seen_q;
  logic             init, acc, rd_acc, sram_clk;
  logic             cen_b, gwen_b;
  logic [MW-1:0]    wen_b, sram_d, sram_q;
  logic [IDX_W-1:0] sram_a;

  assign init      = (state_q == INIT);
  assign init_busy = init;
  assign req_rdy   = ~init;
  assign acc       = req_vld & req_rdy;
  assign rd_acc    = acc & ~req_wr;
  assign rd_vld    = rd_vld_q;

  always_ff @(posedge forever_cpuclk or posedge cpurst)
    if (cpurst) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      rd_vld_q  <= rd_acc;
      rd_seen_q <= rd_seen_q | rd_acc;
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(NUM_SET - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default:
          if (inv_all_req) begin
            state_q <= INIT;
            cnt_q   <= '0;
          end
      endcase
    end

  // Walker writes zero (and parity 0) to every way; requests are blocked meanwhile.
  always_comb begin
    logic [PAR_MAX_W-1:0] ptmp;
    sram_d = '0;
    wen_b  = '1;
    ptmp   = '0;
    for (int w = 0; w < NUM_WAY; w++) begin
      if (!init) sram_d[w*SW +: TAG_W] = req_din[w*TAG_W +: TAG_W];
      ptmp[TAG_W-1:0] = req_din[w*TAG_W +: TAG_W];
`ifdef DCACHE_TAG_PARITY_EN
      if (!init) sram_d[w*SW + TAG_W] = even_par(ptmp);
`endif
      wen_b[w*SW +: SW] = {SW{~(init | req_way_wen[w])}};
    end
  end

  assign cen_b  = ~(acc | init);
  assign gwen_b = ~(init | (acc & req_wr));
  assign sram_a = init ? cnt_q : req_idx;

  gated_clk_cell u_icg (
    .clk_in             (forever_cpuclk),
    .global_en          (1'b1),
    .module_en          (cp0_lsu_icg_en),
    .local_en           (acc | init_busy),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (sram_clk)
  );

  ct_lsu_spsram_bwen #(.DEPTH(NUM_SET), .WIDTH(MW)) u_sram (
    .CLK    (sram_clk),
    .CEN_b  (cen_b),
    .GWEN_b (gwen_b),
    .WEN_b  (wen_b),
    .A      (sram_a),
    .D      (sram_d),
    .Q      (sram_q)
  );

  // SRAM Q is the read register; rd_seen_q gives rd_dout its reset value of zero.
  always_comb begin
    logic [PAR_MAX_W-1:0] qtmp;
    rd_dout = '0;
    par_err = '0;
    qtmp    = '0;
    for (int w = 0; w < NUM_WAY; w++) begin
      if (rd_seen_q) rd_dout[w*TAG_W +: TAG_W] = sram_q[w*SW +: TAG_W];
      qtmp[TAG_W-1:0] = sram_q[w*SW +: TAG_W];
`ifdef DCACHE_TAG_PARITY_EN
      par_err[w] = rd_vld_q & (even_par(qtmp) != sram_q[w*SW + TAG_W]);
`endif
    end
  end
endmodule

// File: tb/tb_ct_lsu_dcache_tag_array_ctrl.sv
// Directed bench for the dcache tag array controller (2 ways, 512 sets, 27-bit tags).
module tb_ct_lsu_dcache_tag_array_ctrl;
  localparam int NW = 2, NS = 512, TW = 27, IW = 9, DW = NW*TW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          scan_en = 1'b0, icg_en = 1'b0;
  logic          req_vld = 1'b0, req_rdy, req_wr = 1'b0;
  logic [IW-1:0] req_idx = '0;
  logic [NW-1:0] req_way_wen = '0;
  logic [DW-1:0] req_din = '0;
  logic          inv_all_req = 1'b0, init_busy, rd_vld;
  logic [DW-1:0] rd_dout;
  logic [NW-1:0] par_err;

  int pass_cnt = 0, tot_cnt = 0;

  localparam logic [DW-1:0] D5  = {27'h1234567, 27'h0ABCDEF};
  localparam logic [DW-1:0] D5P = {27'h1234567, 27'h7FFFFFF};
  localparam logic [DW-1:0] D7  = {27'h0000007, 27'h5555555};
  localparam logic [DW-1:0] D9  = {27'h2AAAAAA, 27'h0000009};
  localparam logic [DW-1:0] D3  = {27'h0F0F0F0, 27'h3333333};

  ct_lsu_dcache_tag_array_ctrl #(.NUM_WAY(NW), .NUM_SET(NS), .TAG_W(TW)) dut (
    .forever_cpuclk     (clk),
    .cpurst             (rst),
    .pad_yy_icg_scan_en (scan_en),
    .cp0_lsu_icg_en     (icg_en),
    .req_vld            (req_vld),
    .req_rdy            (req_rdy),
    .req_wr             (req_wr),
    .req_idx            (req_idx),
    .req_way_wen        (req_way_wen),
    .req_din            (req_din),
    .inv_all_req        (inv_all_req),
    .init_busy          (init_busy),
    .rd_vld             (rd_vld),
    .rd_dout            (rd_dout),
    .par_err            (par_err)
  );

  always #5 clk = ~clk;

  // All stimulus tasks start and end on a falling edge.
  task automatic wr(input logic [IW-1:0] idx, input logic [NW-1:0] wen, input logic [DW-1:0] din);
    req_vld = 1'b1; req_wr = 1'b1; req_idx = idx; req_way_wen = wen; req_din = din;
    @(negedge clk);
    req_vld = 1'b0; req_wr = 1'b0; req_way_wen = '0;
  endtask

  task automatic rd(input logic [IW-1:0] idx);
    req_vld = 1'b1; req_wr = 1'b0; req_idx = idx;
    @(negedge clk);
    req_vld = 1'b0;
  endtask

  // Counts falling edges with init_busy high; optionally pulses inv_all_req mid-walk.
  task automatic walk_len(input int inv_at, output int n, output bit rdy_seen);
    n = 0; rdy_seen = 0;
    while (init_busy === 1'b1 && n < 2000) begin
      if (req_rdy !== 1'b0) rdy_seen = 1;
      inv_all_req = (n == inv_at);
      @(negedge clk);
      inv_all_req = 1'b0;
      n++;
    end
  endtask

  task automatic test_reset;
    int n; bit rs;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    tot_cnt++; if (req_rdy !== 1'b0) $display("FAIL rst_req_rdy got %b want 0", req_rdy); else pass_cnt++;
    tot_cnt++; if (init_busy !== 1'b1) $display("FAIL rst_init_busy got %b want 1", init_busy); else pass_cnt++;
    tot_cnt++; if (rd_vld !== 1'b0) $display("FAIL rst_rd_vld got %b want 0", rd_vld); else pass_cnt++;
    tot_cnt++; if (rd_dout !== '0) $display("FAIL rst_rd_dout got %h want 0", rd_dout); else pass_cnt++;
    tot_cnt++; if (par_err !== '0) $display("FAIL rst_par_err got %b want 0", par_err); else pass_cnt++;
    rst = 1'b0;
    walk_len(-1, n, rs);
    tot_cnt++; if (n != NS) $display("FAIL init_walk_len got %0d want %0d", n, NS); else pass_cnt++;
    tot_cnt++; if (rs) $display("FAIL init_rdy_during_walk got 1 want 0"); else pass_cnt++;
    tot_cnt++; if (req_rdy !== 1'b1) $display("FAIL idle_req_rdy got %b want 1", req_rdy); else pass_cnt++;
  endtask

  task automatic test_init_clear;
    rd(9'd511);
    tot_cnt++; if (rd_vld !== 1'b1) $display("FAIL rd511_vld got %b want 1", rd_vld); else pass_cnt++;
    tot_cnt++; if (rd_dout !== '0) $display("FAIL rd511_dout got %h want 0", rd_dout); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if (rd_vld !== 1'b0) $display("FAIL rd_vld_pulse got %b want 0", rd_vld); else pass_cnt++;
  endtask

  task automatic test_write_read;
    wr(9'd5, 2'b11, D5);
    tot_cnt++; if (rd_vld !== 1'b0) $display("FAIL wr_no_rd_vld got %b want 0", rd_vld); else pass_cnt++;
    tot_cnt++; if (rd_dout !== '0) $display("FAIL wr_dout_held got %h want 0", rd_dout); else pass_cnt++;
    rd(9'd5);
    tot_cnt++; if (rd_vld !== 1'b1) $display("FAIL raw_vld got %b want 1", rd_vld); else pass_cnt++;
    tot_cnt++; if (rd_dout !== D5) $display("FAIL raw_dout got %h want %h", rd_dout, D5); else pass_cnt++;
    tot_cnt++; if (par_err !== '0) $display("FAIL raw_par_err got %b want 0", par_err); else pass_cnt++;
  endtask

  task automatic test_partial;
    wr(9'd5, 2'b01, '1);
    rd(9'd5);
    tot_cnt++; if (rd_dout !== D5P) $display("FAIL partial_wen01 got %h want %h", rd_dout, D5P); else pass_cnt++;
    wr(9'd5, 2'b00, '0);
    rd(9'd5);
    tot_cnt++; if (rd_dout !== D5P) $display("FAIL wen00_noop got %h want %h", rd_dout, D5P); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    wr(9'd7, 2'b11, D7);
    rd(9'd5);
    tot_cnt++; if (rd_vld !== 1'b1 || rd_dout !== D5P) $display("FAIL b2b_first got vld=%b %h want 1 %h", rd_vld, rd_dout, D5P); else pass_cnt++;
    rd(9'd7);
    tot_cnt++; if (rd_vld !== 1'b1 || rd_dout !== D7) $display("FAIL b2b_second got vld=%b %h want 1 %h", rd_vld, rd_dout, D7); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if (rd_vld !== 1'b0 || rd_dout !== D7) $display("FAIL b2b_hold got vld=%b %h want 0 %h", rd_vld, rd_dout, D7); else pass_cnt++;
  endtask

  task automatic test_inv_all;
    int n; bit rs;
    inv_all_req = 1'b1;
    rd(9'd7);
    inv_all_req = 1'b0;
    tot_cnt++; if (rd_vld !== 1'b1 || rd_dout !== D7) $display("FAIL inv_rd_pre_data got vld=%b %h want 1 %h", rd_vld, rd_dout, D7); else pass_cnt++;
    tot_cnt++; if (init_busy !== 1'b1) $display("FAIL inv_busy_rise got %b want 1", init_busy); else pass_cnt++;
    walk_len(50, n, rs);
    tot_cnt++; if (n != NS) $display("FAIL inv_walk_len got %0d want %0d", n, NS); else pass_cnt++;
    rd(9'd7);
    tot_cnt++; if (rd_dout !== '0) $display("FAIL inv_clear7 got %h want 0", rd_dout); else pass_cnt++;
    rd(9'd5);
    tot_cnt++; if (rd_dout !== '0) $display("FAIL inv_clear5 got %h want 0", rd_dout); else pass_cnt++;
  endtask

  task automatic test_reset_mid_walk;
    int n; bit rs;
    inv_all_req = 1'b1;
    @(negedge clk);
    inv_all_req = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    #1;
    tot_cnt++; if (init_busy !== 1'b1 || req_rdy !== 1'b0) $display("FAIL midwalk_rst got busy=%b rdy=%b want 1 0", init_busy, req_rdy); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    walk_len(-1, n, rs);
    tot_cnt++; if (n != NS) $display("FAIL midwalk_restart_len got %0d want %0d", n, NS); else pass_cnt++;
  endtask

  task automatic test_reset_mid_read;
    int n; bit rs;
    wr(9'd9, 2'b11, D9);
    rd(9'd9);
    tot_cnt++; if (rd_vld !== 1'b1 || rd_dout !== D9) $display("FAIL midread_pre got vld=%b %h want 1 %h", rd_vld, rd_dout, D9); else pass_cnt++;
    rst = 1'b1;
    #1;
    tot_cnt++; if (rd_vld !== 1'b0) $display("FAIL midread_rst_vld got %b want 0", rd_vld); else pass_cnt++;
    tot_cnt++; if (rd_dout !== '0) $display("FAIL midread_rst_dout got %h want 0", rd_dout); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    walk_len(-1, n, rs);
    tot_cnt++; if (n != NS) $display("FAIL midread_walk_len got %0d want %0d", n, NS); else pass_cnt++;
  endtask

  task automatic test_parity;
    logic [DW-1:0] exp_flip;
    wr(9'd3, 2'b11, D3);
    rd(9'd3);
    tot_cnt++; if (rd_dout !== D3) $display("FAIL par_dout got %h want %h", rd_dout, D3); else pass_cnt++;
    tot_cnt++; if (par_err !== 2'b00) $display("FAIL par_clean got %b want 00", par_err); else pass_cnt++;
`ifdef DCACHE_TAG_PARITY_EN
    exp_flip = D3 ^ (DW'(1) << TW);
    dut.u_sram.mem[3][TW+1] = ~dut.u_sram.mem[3][TW+1];
    rd(9'd3);
    tot_cnt++; if (par_err !== 2'b10) $display("FAIL par_flip got %b want 10", par_err); else pass_cnt++;
    tot_cnt++; if (rd_dout !== exp_flip) $display("FAIL par_flip_dout got %h want %h", rd_dout, exp_flip); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if (par_err !== 2'b00) $display("FAIL par_qual got %b want 00", par_err); else pass_cnt++;
`else
    exp_flip = D3;
    @(negedge clk);
    tot_cnt++; if (par_err !== 2'b00 || rd_dout !== exp_flip) $display("FAIL par_off got %b %h want 00 %h", par_err, rd_dout, exp_flip); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset;
    test_init_clear;
    test_write_read;
    test_partial;
    test_back_to_back;
    test_inv_all;
    test_reset_mid_walk;
    test_reset_mid_read;
    test_parity;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/ct_lsu_dcache_tag_array_ctrl.md
Name: ct_lsu_dcache_tag_array_ctrl

Overview:
- Parametrised successor to the fixed two-way load-side dcache tag array.
- Wraps a per-way-write-enabled single-port tag SRAM behind a valid/ready request port with a registered one-cycle read.
- Adds a hardware invalidate-all walker that runs after reset and on request.
- Sits between LSU pipe stage tag-read/refill logic and the SRAM macro. Way count, set count and tag width are generic.

Parameters:
NUM_WAY, 2, number of ways stored per index
NUM_SET, 512, number of indexes; power of two, 64..1024
TAG_W, 27, bits per way entry (tag + state)
IDX_W, $clog2(NUM_SET), index width (derived; do not override)

Ports:
forever_cpuclk  in  1  free-running core clock
cpurst  in  1  asynchronous, active-high reset
pad_yy_icg_scan_en  in  1  scan enable for gated clock cell
cp0_lsu_icg_en  in  1  module-level clock-gate enable
req_vld  in  1  access request valid
req_rdy  out  1  access accepted when req_vld & req_rdy
req_wr  in  1  1 = write, 0 = read
req_idx  in  IDX_W  set index
req_way_wen  in  NUM_WAY  per-way write enable; ignored for reads
req_din  in  NUM_WAY*TAG_W  write data; way w at [w*TAG_W +: TAG_W]
inv_all_req  in  1  pulse: invalidate every index, all ways
init_busy  out  1  invalidate walk in progress
rd_vld  out  1  read data valid, one cycle after accepted read
rd_dout  out  NUM_WAY*TAG_W  read data, held until next accepted read
par_err  out  NUM_WAY  per-way parity error, qualified by rd_vld

Behaviour:
- Reset values: req_rdy=0, init_busy=1, rd_vld=0, rd_dout=0, par_err=0; FSM=INIT, walk counter=0.
- FSM states are IDLE and INIT.
- INIT:
  - Each cycle writes zero to all ways at index cnt; cnt increments.
  - At cnt==NUM_SET-1, the write occurs and the FSM moves to IDLE the next cycle. Walk length is exactly NUM_SET cycles.
  - req_rdy=0 and init_busy=1 throughout. inv_all_req is ignored, not queued.
- IDLE:
  - req_rdy=1 and init_busy=0.
  - inv_all_req=1 causes INIT next cycle with cnt=0.
  - A request accepted in the same cycle completes normally; its read data still returns.
- Reads:
  - SRAM is enabled with no write.
  - rd_vld=1 the next cycle and rd_dout is updated from SRAM Q.
  - rd_vld is a single-cycle pulse per read. Back-to-back reads give rd_vld every cycle.
- Writes:
  - Bits of way w are written only if req_way_wen[w].
  - rd_vld is not asserted and rd_dout is unchanged.
  - A write with req_way_wen==0 is accepted as a no-op.
- Read-after-write to the same index on the next cycle returns the newly written data. There is no bypass path; the SRAM serialises.
- Clock gating: gated_clk_cell local_en = (req_vld & req_rdy) | init_busy, module_en=cp0_lsu_icg_en. external_en=0, global_en=1.
- SRAM controls are active-low internally: CEN_b = ~access, GWEN_b = ~write, WEN_b per bit = ~way enable replicated TAG_W times.
- Reset asserted mid-walk or mid-read: rd_vld clears immediately; the walk restarts from index 0 after deassertion. SRAM contents are not reset.

Optional Feature:
DCACHE_TAG_PARITY_EN
- Defined:
  - Each way stores TAG_W+1 bits; the extra bit is even parity of that way's data, generated on write.
  - The INIT walker writes parity 0.
  - On read, par_err[w] = recomputed parity != stored parity, registered alongside rd_dout, valid with rd_vld and cleared otherwise.
  - rd_dout excludes the parity bits.
- Undefined: storage is NUM_WAY*TAG_W and par_err is tied to 0.

Decomposition:
- Package ct_lsu_dcache_pkg:
  - FSM state typedef (IDLE/INIT).
  - Function returning the stored way width (TAG_W or TAG_W+1).
  - Parity function.
- Sub-module ct_lsu_spsram_bwen #(DEPTH, WIDTH): single-port, active-low CEN/GWEN/per-bit WEN, one-cycle Q.
  - Behavioural model in simulation; swapped for the macro in implementation.

Test Plan:
- Reset, then release → init_busy=1, req_rdy=0 for exactly 512 cycles; a read of idx 511 afterwards returns all zero.
- After init, write idx 5, wen=2'b11, din={27'h1234567,27'h0ABCDEF}; read idx 5 next cycle → rd_vld one cycle later, rd_dout equals din.
- Write idx 5, wen=2'b01, din=all ones; read idx 5 → low 27 bits all ones, high way still 27'h1234567.
- Read idx 7 accepted the same cycle as inv_all_req → rd_vld next cycle with the pre-invalidate data. init_busy rises the same cycle rd_vld is high; a second inv_all_req mid-walk does not extend the 512 cycles.
- Assert cpurst at walk cycle 100 → rd_vld=0 and init_busy=1 immediately; the walk restarts from 0 and again lasts 512 cycles.
- DCACHE_TAG_PARITY_EN: force-flip a stored bit of way 1 at idx 3, then read → par_err=2'b10 with rd_vld. Without the macro, par_err stays 0.
